// File: rtl/spi_slave_frame_if.sv
// SPI pin and word-handshake bundle between the pad ring / register block and spi_slave_frame.
interface spi_slave_frame_if #(
    parameter int unsigned DATA_W = 32
);
    logic              sclk;
    logic              mosi;
    logic              ss_n;
    logic              miso;
    logic [1:0]        mode;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ack;
    logic              rx_overrun;
    logic              tx_underrun;
    logic              frame_abort;
    logic              busy;

    modport slave (
        input  sclk, mosi, ss_n, mode, tx_data, tx_load, rx_ack,
        output miso, tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun, frame_abort, busy
    );

    modport master (
        output sclk, mosi, ss_n, mode, tx_data, tx_load, rx_ack,
        input  miso, tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun, frame_abort, busy
    );
endinterface

// File: rtl/spi_slave_frame.sv
// Oversampled SPI slave, all four modes, MSB-first DATA_W words, double-buffered TX,
// valid/ack RX with overrun, underrun and abort reporting.
module spi_slave_frame #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       SYNC_STAGES = 3,
    parameter logic [DATA_W-1:0] IDLE_WORD   = DATA_W'(32'hDEADBEEF)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    spi_slave_frame_if.slave    bus
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic {IDLE, ACTIVE} state_e;

    // Pin synchronisers plus one history flop each for edge detection
    logic [SYNC_STAGES-1:0] sclk_sync_q, ss_n_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, ss_n_prev_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= '0;
            ss_n_sync_q <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_n_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            ss_n_sync_q <= {ss_n_sync_q[SYNC_STAGES-2:0], bus.ss_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            ss_n_prev_q <= ss_n_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s, ss_n_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_fall, ss_rise;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_n_s    = ss_n_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ss_fall   = ~ss_n_s & ss_n_prev_q;
    assign ss_rise   = ss_n_s & ~ss_n_prev_q;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_shreg_q, rx_shreg_d;
    logic [DATA_W-1:0] tx_shreg_q, tx_shreg_d;
    logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              tx_ready_q, tx_ready_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_overrun_q, rx_overrun_d;
    logic              tx_underrun_q, tx_underrun_d;
    logic              frame_abort_q, frame_abort_d;
    logic              miso_q, miso_d;
    logic              busy_q, busy_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;

    logic sample_edge_c, shift_edge_c, reload_c;

    // Sampling happens on the rising edge exactly when CPOL equals CPHA
    assign sample_edge_c = (cpol_q == cpha_q) ? sclk_rise : sclk_fall;
    assign shift_edge_c  = (cpol_q == cpha_q) ? sclk_fall : sclk_rise;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shreg_d    = rx_shreg_q;
        tx_shreg_d    = tx_shreg_q;
        tx_buf_d      = tx_buf_q;
        rx_data_d     = rx_data_q;
        tx_ready_d    = tx_ready_q;
        rx_valid_d    = rx_valid_q;
        rx_overrun_d  = rx_overrun_q;
        tx_underrun_d = tx_underrun_q;
        frame_abort_d = 1'b0;
        cpol_d        = cpol_q;
        cpha_d        = cpha_q;
        reload_c      = 1'b0;

        if (bus.rx_ack) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (ss_fall) begin
                    cpol_d   = bus.mode[1];
                    cpha_d   = bus.mode[0];
                    reload_c = 1'b1;
                    state_d  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d    = IDLE;
                    bit_cnt_d  = '0;
                    rx_shreg_d = '0;
                    tx_shreg_d = '0;
                    if (bit_cnt_q != '0) begin
                        frame_abort_d = 1'b1;
                    end
                end else if (sample_edge_c) begin
                    rx_shreg_d = {rx_shreg_q[DATA_W-2:0], mosi_s};
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        rx_data_d  = rx_shreg_d;
                        rx_valid_d = 1'b1;
                        if (rx_valid_q && !bus.rx_ack) begin
                            rx_overrun_d = 1'b1;
                        end
                        bit_cnt_d = '0;
                        reload_c  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (shift_edge_c && (bit_cnt_q != '0)) begin
                    // A zero count marks a freshly loaded word whose MSB must stay on miso
                    tx_shreg_d = {tx_shreg_q[DATA_W-2:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase

        if (reload_c) begin
            if (!tx_ready_q) begin
                tx_shreg_d = tx_buf_q;
                tx_ready_d = 1'b1;
            end else begin
                tx_shreg_d    = IDLE_WORD;
                tx_underrun_d = 1'b1;
            end
        end

        // Uses the pre-reload ready flag, so a same-cycle load lands in the freed buffer
        if (bus.tx_load && tx_ready_q) begin
            tx_buf_d   = bus.tx_data;
            tx_ready_d = 1'b0;
        end

        if (!enable) begin
            state_d       = IDLE;
            bit_cnt_d     = '0;
            rx_shreg_d    = '0;
            tx_shreg_d    = '0;
            tx_buf_d      = '0;
            rx_data_d     = '0;
            tx_ready_d    = 1'b1;
            rx_valid_d    = 1'b0;
            rx_overrun_d  = 1'b0;
            tx_underrun_d = 1'b0;
            frame_abort_d = 1'b0;
            cpol_d        = 1'b0;
            cpha_d        = 1'b0;
        end

        miso_d = (state_d == ACTIVE) ? tx_shreg_d[DATA_W-1] : 1'b0;
        busy_d = (state_d == ACTIVE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            rx_shreg_q    <= '0;
            tx_shreg_q    <= '0;
            tx_buf_q      <= '0;
            rx_data_q     <= '0;
            tx_ready_q    <= 1'b1;
            rx_valid_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_abort_q <= 1'b0;
            miso_q        <= 1'b0;
            busy_q        <= 1'b0;
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shreg_q    <= rx_shreg_d;
            tx_shreg_q    <= tx_shreg_d;
            tx_buf_q      <= tx_buf_d;
            rx_data_q     <= rx_data_d;
            tx_ready_q    <= tx_ready_d;
            rx_valid_q    <= rx_valid_d;
            rx_overrun_q  <= rx_overrun_d;
            tx_underrun_q <= tx_underrun_d;
            frame_abort_q <= frame_abort_d;
            miso_q        <= miso_d;
            busy_q        <= busy_d;
            cpol_q        <= cpol_d;
            cpha_q        <= cpha_d;
        end
    end

    assign bus.miso        = miso_q;
    assign bus.tx_ready    = tx_ready_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rx_overrun  = rx_overrun_q;
    assign bus.tx_underrun = tx_underrun_q;
    assign bus.frame_abort = frame_abort_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_spi_slave_frame.sv
// Directed bench for spi_slave_frame: the bench acts as SPI master with slow sclk phases.
module tb_spi_slave_frame;
    localparam int unsigned DW = 32;
    localparam int unsigned SS = 3;
    localparam int unsigned H  = 8;

    logic clock = 1'b0;
    logic reset;
    logic enable;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clock = ~clock;

    spi_slave_frame_if #(.DATA_W(DW)) bus ();

    spi_slave_frame #(
        .DATA_W     (DW),
        .SYNC_STAGES(SS),
        .IDLE_WORD  (32'hDEADBEEF)
    ) dut (
        .clock (clock),
        .reset (reset),
        .enable(enable),
        .bus   (bus)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic load_tx(input logic [31:0] w);
        bus.tx_data = w;
        bus.tx_load = 1'b1;
        tick(1);
        bus.tx_load = 1'b0;
    endtask

    task automatic start_sel(input logic [1:0] md);
        bus.mode = md;
        bus.sclk = md[1];
        tick(H);
        bus.ss_n = 1'b0;
        tick(H);
    endtask

    task automatic end_sel();
        tick(H);
        bus.ss_n = 1'b1;
        tick(2 * H);
    endtask

    task automatic ack();
        bus.rx_ack = 1'b1;
        tick(1);
        bus.rx_ack = 1'b0;
    endtask

    task automatic clear_en();
        enable = 1'b0;
        tick(2);
        enable = 1'b1;
        tick(2);
    endtask

    // Master side of one word: drives mosi, captures miso at each sample edge
    task automatic send_word(input logic [1:0] md, input logic [31:0] mo, input int nbits,
                             output logic [31:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            if (md[0]) begin
                bus.sclk = ~md[1];
                bus.mosi = mo[31-i];
                tick(H);
                bus.sclk = md[1];
                mi[31-i] = bus.miso;
                tick(H);
            end else begin
                bus.mosi = mo[31-i];
                tick(H);
                bus.sclk = ~md[1];
                mi[31-i] = bus.miso;
                tick(H);
                bus.sclk = md[1];
            end
        end
    endtask

    initial begin
        logic [31:0] mi;
        logic [31:0] mi2;
        int          pulses;

        reset       = 1'b1;
        enable      = 1'b1;
        bus.sclk    = 1'b0;
        bus.mosi    = 1'b0;
        bus.ss_n    = 1'b1;
        bus.mode    = 2'b00;
        bus.tx_data = '0;
        bus.tx_load = 1'b0;
        bus.rx_ack  = 1'b0;
        tick(3);
        check("rst_miso", 32'(bus.miso), 32'd0);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_rx_data", bus.rx_data, 32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_flags", {28'd0, bus.rx_overrun, bus.tx_underrun, bus.frame_abort, bus.busy}, 32'd0);
        reset = 1'b0;
        tick(10);

        // Mode 0 single word with preloaded TX
        load_tx(32'hA5A5_0F0F);
        check("m0_tx_ready_full", 32'(bus.tx_ready), 32'd0);
        start_sel(2'd0);
        check("m0_busy", 32'(bus.busy), 32'd1);
        send_word(2'd0, 32'h1234_5678, 32, mi);
        end_sel();
        check("m0_miso_stream", mi, 32'hA5A5_0F0F);
        check("m0_rx_data", bus.rx_data, 32'h1234_5678);
        check("m0_rx_valid", 32'(bus.rx_valid), 32'd1);
        check("m0_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("m0_busy_end", 32'(bus.busy), 32'd0);
        check("m0_overrun", 32'(bus.rx_overrun), 32'd0);
        ack();
        check("m0_ack_clears", 32'(bus.rx_valid), 32'd0);

        // Modes 1..3
        for (int m = 1; m < 4; m++) begin
            load_tx(32'hC3C3_3C3C);
            start_sel(2'(m));
            send_word(2'(m), 32'h8000_0001, 32, mi);
            end_sel();
            check($sformatf("mode%0d_miso", m), mi, 32'hC3C3_3C3C);
            check($sformatf("mode%0d_rx", m), bus.rx_data, 32'h8000_0001);
            ack();
        end

        // Back-to-back words, refill after the select reload, no ack between words
        for (int m = 0; m < 2; m++) begin
            clear_en();
            check("b2b_clear_ovr", 32'(bus.rx_overrun), 32'd0);
            load_tx(32'h1111_2222);
            start_sel(2'(m));
            load_tx(32'h3333_4444);
            send_word(2'(m), 32'hAAAA_5555, 32, mi);
            check("b2b_rx1", bus.rx_data, 32'hAAAA_5555);
            send_word(2'(m), 32'h0F0F_F0F0, 32, mi2);
            end_sel();
            check($sformatf("b2b%0d_miso1", m), mi, 32'h1111_2222);
            check($sformatf("b2b%0d_miso2", m), mi2, 32'h3333_4444);
            check("b2b_rx2", bus.rx_data, 32'h0F0F_F0F0);
            check("b2b_valid", 32'(bus.rx_valid), 32'd1);
            check("b2b_overrun", 32'(bus.rx_overrun), 32'd1);
        end

        // Empty TX buffer at select
        clear_en();
        check("en_clear_underrun", 32'(bus.tx_underrun), 32'd0);
        check("en_clear_valid", 32'(bus.rx_valid), 32'd0);
        start_sel(2'd2);
        check("empty_underrun", 32'(bus.tx_underrun), 32'd1);
        send_word(2'd2, 32'h5A5A_5A5A, 32, mi);
        end_sel();
        check("empty_miso", mi, 32'hDEAD_BEEF);
        check("empty_rx", bus.rx_data, 32'h5A5A_5A5A);

        // Abort after 13 bits with rx_valid still set from the previous word
        start_sel(2'd0);
        send_word(2'd0, 32'hFFFF_0000, 13, mi);
        tick(H);
        bus.ss_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3 * H; i++) begin
            tick(1);
            if (bus.frame_abort) pulses++;
        end
        check("abort_pulses", 32'(pulses), 32'd1);
        check("abort_valid_kept", 32'(bus.rx_valid), 32'd1);
        check("abort_rx_kept", bus.rx_data, 32'h5A5A_5A5A);
        check("abort_idle", 32'(bus.busy), 32'd0);
        ack();
        load_tx(32'h0F1E_2D3C);
        start_sel(2'd0);
        send_word(2'd0, 32'h8765_4321, 32, mi);
        end_sel();
        check("post_abort_miso", mi, 32'h0F1E_2D3C);
        check("post_abort_rx", bus.rx_data, 32'h8765_4321);
        ack();

        // Reset at bit 20
        load_tx(32'h1357_9BDF);
        start_sel(2'd0);
        send_word(2'd0, 32'hFFFF_FFFF, 20, mi);
        reset = 1'b1;
        tick(2);
        check("midrst_outs", {bus.miso, bus.tx_ready, bus.rx_valid, bus.rx_overrun,
                              bus.tx_underrun, bus.frame_abort, bus.busy}, 32'b0100000);
        check("midrst_rx_data", bus.rx_data, 32'd0);
        bus.sclk = 1'b0;
        reset = 1'b0;
        tick(10);
        check("midrst_wait_high", 32'(bus.busy), 32'd0);
        bus.ss_n = 1'b1;
        tick(2 * H);
        check("midrst_still_idle", 32'(bus.busy), 32'd0);

        // Load lands in the same cycle as the select reload
        bus.mode = 2'd0;
        bus.ss_n = 1'b0;
        tick(SS);
        bus.tx_data = 32'hCAFE_F00D;
        bus.tx_load = 1'b1;
        tick(1);
        bus.tx_load = 1'b0;
        check("same_cyc_busy", 32'(bus.busy), 32'd1);
        check("same_cyc_buf_full", 32'(bus.tx_ready), 32'd0);
        check("same_cyc_underrun", 32'(bus.tx_underrun), 32'd1);
        tick(H);
        send_word(2'd0, 32'h2468_ACE0, 32, mi);
        check("postrst_rx1", bus.rx_data, 32'h2468_ACE0);
        send_word(2'd0, 32'hFEDC_BA98, 32, mi2);
        end_sel();
        check("same_cyc_old_word", mi, 32'hDEAD_BEEF);
        check("same_cyc_new_word", mi2, 32'hCAFE_F00D);
        check("postrst_rx2", bus.rx_data, 32'hFEDC_BA98);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/spi_slave_frame.md
# spi_slave_frame

Parametrised SPI slave for the actuator-controller user area. It oversamples `sclk`, `ss_n` and `mosi` on the system `clock` and supports all four SPI modes. Words are `DATA_W` bits, MSB-first, and back-to-back words may be sent within one select. The TX path is double-buffered and the RX path has a valid/ack handshake with overrun, underrun and abort reporting. It sits between the chip-level SPI pads and the register/command block.

## Interface
- `DATA_W`, 32, word length in bits (≥ 4)
- `SYNC_STAGES`, 3, synchroniser depth on `sclk`/`ss_n`/`mosi` (≥ 2)
- `IDLE_WORD`, 32'hDEADBEEF (truncated to `DATA_W`), word shifted out when the TX buffer is empty
- `clock`  input  1  system clock; all logic on its rising edge
- `reset`  input  1  asynchronous, active-high reset
- `enable`  input  1  block enable; low = synchronous clear to reset state (synchronisers keep running)
- `sclk`, `mosi`, `ss_n`  input  1 each  asynchronous SPI pins
- `miso`  output  1  serial out, registered
- `mode`  input  2  {CPOL, CPHA}; captured at select assertion
- `tx_data`  input  DATA_W  next word to transmit
- `tx_load`  input  1  write strobe for `tx_data`; ignored when `tx_ready`=0
- `tx_ready`  output  1  TX buffer empty
- `rx_data`  output  DATA_W  last received word
- `rx_valid`  output  1  level, set on word completion
- `rx_ack`  input  1  clears `rx_valid`
- `rx_overrun`  output  1  sticky: word completed while `rx_valid`=1
- `tx_underrun`  output  1  sticky: `IDLE_WORD` was used for a word
- `frame_abort`  output  1  one-cycle pulse: select released with a partial word
- `busy`  output  1  high in state ACTIVE

## Operation
- Sync: each pin passes through `SYNC_STAGES` flops. Edges are taken from the last two stages (`s_n` = synchronised value).
- Leading edge = first `sclk` edge after CPOL idle level. Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other edge.
- States:
  - IDLE: `ss_n_s`=1; `miso`=0, `bit_cnt`=0.
  - On `ss_n_s` falling: latch `mode`; load `tx_shreg` from TX buffer, else `IDLE_WORD` and set `tx_underrun`; buffer → empty; → ACTIVE.
- ACTIVE, sample edge: `rx_shreg` ← {`rx_shreg`[DATA_W-2:0], `mosi_s`}; `bit_cnt`++.
  - When the count reaches `DATA_W`: `rx_data` ← full word; `rx_valid`←1 (if already 1 then `rx_overrun`←1 and `rx_data` is overwritten); `bit_cnt`←0; reload `tx_shreg` exactly as at select.
- ACTIVE, shift edge: shift `tx_shreg` left only if `bit_cnt`≠0. This suppresses the CPHA=1 first-leading-edge shift and the CPHA=0 post-word trailing shift.
- `miso` = `tx_shreg`[DATA_W-1] in ACTIVE, 0 in IDLE.
- `ss_n_s` rising in ACTIVE → IDLE.
  - If `bit_cnt`≠0: partial word discarded; `frame_abort` pulses; `rx_valid` is not affected.
- `rx_ack` clears `rx_valid` the next cycle. If an ack and a word completion fall in the same cycle: `rx_valid` stays 1 and there is no overrun.
- `tx_load` while `tx_ready`: buffer ← `tx_data`, `tx_ready`←0. If a load and a reload fall in the same cycle, the reload takes the old buffer contents and the buffer then holds the new word.
- Sticky flags clear only on `reset` or `enable`=0.
- `mode` changes while ACTIVE are ignored.

## Timing
- Reset / `enable`=0 values:
  - `miso`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0.
  - `rx_overrun`=0, `tx_underrun`=0, `frame_abort`=0, `busy`=0.
  - State IDLE, all shift registers 0.
- Reset mid-frame: immediate return to IDLE. A new frame starts only on a fresh `ss_n` falling edge seen after reset release. If `ss_n` is already low at release, the block waits for `ss_n` high then low.
- Pin-to-action latency: `SYNC_STAGES`+1 clock edges from the first `clock` edge that samples a pin transition to the register update (`rx_valid`, `miso`, `busy`).
- `sclk` high and low phases must each be ≥ `SYNC_STAGES`+2 clock periods.
- `ss_n` setup before the first `sclk` edge and hold after the last edge: ≥ `SYNC_STAGES`+2 clocks.
- `rx_valid` rises one cycle after the internal last-bit sample edge. `frame_abort` is high for exactly 1 cycle.

## Test plan
- Mode 0, `DATA_W`=32, TX preloaded 32'hA5A5_0F0F, master sends 32'h1234_5678 → `miso` stream = A5A50F0F MSB-first; `rx_data`=32'h12345678; `rx_valid`=1; `tx_ready`=1.
- Modes 1/2/3 each with TX 32'hC3C3_3C3C and RX 32'h8000_0001 → identical data at both ends; no extra or missing shift at word boundaries.
- Two back-to-back words in one select, TX buffer refilled after the first reload, `rx_ack` withheld → second `rx_data` valid; `rx_overrun`=1.
- Empty TX buffer at select → `miso` stream = 32'hDEADBEEF; `tx_underrun`=1.
- `ss_n` released after 13 bits → `frame_abort` 1-cycle pulse; `rx_valid` unchanged; next full frame is received correctly.
- `reset` asserted at bit 20, released, full frame sent → all outputs at reset values during reset; clean 32-bit receive afterwards; `tx_load` + reload in the same cycle → old word sent, new word retained.
